fetch_controller: RTL and testbench

Sequences instruction fetch for the RISC-V core. The block owns the architectural PC and drives the instruction-memory request/response handshake. It applies branch, jump and jalr redirects from execute, and holds a fetched instruction until decode accepts it. It sits between the instruction memory and decode and replaces free-running PC increment with a handshake-aware sequencer.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/next_pc_calc.sv | 29 ++
 rtl/fetch_controller.sv | 149 ++++++++++++++
 tb/tb_fetch_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] JALR_MASK = 32'hFFFF_FFFE;

endpackage

// File: rtl/next_pc_calc.sv
// Redirect target and redirect flag from the execute-stage control-flow inputs.
// Purely combinational (0 cycles); no handshake, so it has no backpressure.
module next_pc_calc
    import fetch_ctrl_pkg::*;
(
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic        is_jalr,
    input  logic [31:0] pc_exec,
    input  logic [31:0] src1_value,
    input  logic [31:0] imm_value,
    output logic        redirect,
    output logic [31:0] target
);

    logic [31:0] jalr_sum;

    assign jalr_sum = src1_value + imm_value;
    assign redirect = is_branch | is_jump | is_jalr;

    // jal and taken branches share the PC-relative form, so only jalr needs to win.
    always_comb begin
        target = pc_exec + imm_value;
        if (is_jalr) begin
            target = jalr_sum & JALR_MASK;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Owns the PC and sequences one-outstanding imem fetches into a decode holding slot; 3 cycles/instr.
// Decode backpressure via stall holds the slot; redirects override stall and flush in-flight work.
// FETCH_CTRL_TIMEOUT_EN adds a response watchdog driving fetch_error.
module fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic        is_jalr,
    input  logic [31:0] pc_exec,
    input  logic [31:0] src1_value,
    input  logic [31:0] imm_value,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc,
    output logic        flush,
    output logic        fetch_error
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  inflight_pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;
    logic         flush_q;
    logic         redirect;
    logic [31:0]  target;
    logic         timeout;

    next_pc_calc u_next_pc_calc (
        .is_branch  (is_branch),
        .is_jump    (is_jump),
        .is_jalr    (is_jalr),
        .pc_exec    (pc_exec),
        .src1_value (src1_value),
        .imm_value  (imm_value),
        .redirect   (redirect),
        .target     (target)
    );

`ifdef FETCH_CTRL_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] tmo_cnt_q;
    logic       fetch_error_q;
    logic       watching;

    assign watching = (state_q == WAIT) || (state_q == DROP);
    assign timeout  = watching && !imem_rsp_valid && !redirect &&
                      ((tmo_cnt_q + 8'd1) == TMO_LIMIT);

    // Clearing on every non-counting cycle also gives a fresh count on each state entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q     <= '0;
            fetch_error_q <= 1'b0;
        end else begin
            if (timeout) begin
                fetch_error_q <= 1'b1;
            end
            if (watching && !imem_rsp_valid && !timeout && !(redirect && state_q == WAIT)) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end else begin
                tmo_cnt_q <= '0;
            end
        end
    end

    assign fetch_error = fetch_error_q;
`else
    assign timeout     = 1'b0;
    assign fetch_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            flush_q       <= 1'b0;
        end else begin
            flush_q <= redirect;
            if (redirect) begin
                pc_q <= target;
            end
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    if (imem_ready) begin
                        inflight_pc_q <= pc_q;
                        if (redirect) begin
                            state_q <= DROP;
                        end else begin
                            pc_q    <= pc_q + PC_STEP;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        // A response landing with the redirect is simply discarded.
                        state_q <= imem_rsp_valid ? REQ : DROP;
                    end else if (imem_rsp_valid) begin
                        instr_q    <= imem_rsp_data;
                        instr_pc_q <= inflight_pc_q;
                        state_q    <= HOLD;
                    end else if (timeout) begin
                        pc_q    <= inflight_pc_q;
                        state_q <= REQ;
                    end
                end
                HOLD: begin
                    if (redirect || !stall) begin
                        state_q <= REQ;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid || timeout) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;
    assign flush       = flush_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboarded bench for fetch_controller: two instances (RESET_PC 0 and 0xFFFF_FFFC) on one stimulus bus.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        is_branch, is_jump, is_jalr;
    logic [31:0] pc_exec, src1_value, imm_value;
    logic        imem_ready, imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    logic        imem_req, instr_valid, flush, fetch_error;
    logic [31:0] imem_addr, instr, instr_pc, pc;
    logic        w_imem_req, w_instr_valid, w_flush, w_fetch_error;
    logic [31:0] w_imem_addr, w_instr, w_instr_pc, w_pc;

    logic [63:0] sb_q[$];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_controller #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .is_branch(is_branch), .is_jump(is_jump), .is_jalr(is_jalr),
        .pc_exec(pc_exec), .src1_value(src1_value), .imm_value(imm_value),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .pc(pc), .flush(flush), .fetch_error(fetch_error)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(4)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .is_branch(is_branch), .is_jump(is_jump), .is_jalr(is_jalr),
        .pc_exec(pc_exec), .src1_value(src1_value), .imm_value(imm_value),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
        .pc(w_pc), .flush(w_flush), .fetch_error(w_fetch_error)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        logic [63:0] e;
        int n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_instr"}, instr, e[31:0]);
            chk({tag, "_instr_pc"}, instr_pc, e[63:32]);
        end
    endtask

    // Zero-wait memory transaction at the expected address; the word is queued as the expected delivery.
    task automatic serve(input logic [31:0] addr, input logic [31:0] data, input string tag);
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk({tag, "_pc_step"}, pc, addr + 32'd4);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        sb_q.push_back({addr, data});
        step();
        imem_rsp_valid = 1'b0;
        pop_check(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n = 1'b0; stall = 1'b0;
        is_branch = 1'b0; is_jump = 1'b0; is_jalr = 1'b0;
        pc_exec = '0; src1_value = '0; imm_value = '0;
        imem_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        repeat (2) step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_err", 32'(fetch_error), 32'd0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);

        // Wrap and backpressure on the high-RESET_PC instance.
        reset_n = 1'b1;
        step();
        chk("wrap_req0", 32'(w_imem_req), 32'd1);
        chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wrap_bp_req", 32'(w_imem_req), 32'd1);
            chk("wrap_bp_addr", w_imem_addr, 32'hFFFF_FFFC);
        end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("wrap_pc", w_pc, 32'h0);
        chk("wrap_req_drop", 32'(w_imem_req), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        chk("wrap_valid", 32'(w_instr_valid), 32'd1);
        chk("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", w_instr, 32'h0000_0013);

        // Mid-operation reset, then release with a stale response pending.
        stall = 1'b1;
        step();
        reset_n = 1'b0;
        #1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("midrst_wrap_valid", 32'(w_instr_valid), 32'd0);
        stall = 1'b0;
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0BAD;
        reset_n = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        chk("seq_e1_valid", 32'(instr_valid), 32'd0);
        chk("seq_e1_req", 32'(imem_req), 32'd1);
        chk("seq_e1_addr", imem_addr, 32'h0);
        chk("seq_e1_instr", instr, 32'h0);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("seq_e2_valid", 32'(instr_valid), 32'd0);
        chk("seq_e2_pc", pc, 32'h4);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        sb_q.push_back({32'h0, 32'h0000_0013});
        step();
        imem_rsp_valid = 1'b0;
        chk("seq_e3_valid", 32'(instr_valid), 32'd1);
        pop_check("seq");
        chk("seq_pc", pc, 32'h4);

        // Stall holds the instruction and blocks new requests.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", instr, 32'h0000_0013);
            chk("stall_no_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        step();
        chk("unstall_req", 32'(imem_req), 32'd1);
        chk("unstall_addr", imem_addr, 32'h4);

        // Taken branch while waiting: stale response dropped.
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        is_branch = 1'b1; pc_exec = 32'h10; imm_value = 32'h8;
        step();
        is_branch = 1'b0;
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_pc", pc, 32'h18);
        chk("br_drop_no_req", 32'(imem_req), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("br_flush_once", 32'(flush), 32'd0);
        chk("br_stale_valid", 32'(instr_valid), 32'd0);
        serve(32'h18, 32'h0050_0093, "br_fetch");

        // jalr in HOLD overrides stall and clears the LSB.
        stall = 1'b1;
        is_jalr = 1'b1; src1_value = 32'h12; imm_value = 32'h1;
        step();
        is_jalr = 1'b0; stall = 1'b0;
        chk("jalr_valid", 32'(instr_valid), 32'd0);
        chk("jalr_flush", 32'(flush), 32'd1);
        serve(32'h12, 32'h0020_8133, "jalr_fetch");

        // Redirect in REQ without acceptance moves the pending address.
        step();
        chk("req_addr_pre", imem_addr, 32'h16);
        is_jump = 1'b1; pc_exec = 32'h100; imm_value = 32'h20;
        step();
        is_jump = 1'b0;
        chk("req_redir_req", 32'(imem_req), 32'd1);
        chk("req_redir_addr", imem_addr, 32'h120);

        // Redirect coinciding with a WAIT response; jalr outranks jump and branch.
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
        is_jalr = 1'b1; is_jump = 1'b1; is_branch = 1'b1;
        src1_value = 32'h301; pc_exec = 32'h200; imm_value = 32'h4;
        step();
        imem_rsp_valid = 1'b0;
        is_jalr = 1'b0; is_jump = 1'b0; is_branch = 1'b0;
        chk("prio_req", 32'(imem_req), 32'd1);
        chk("prio_addr", imem_addr, 32'h304);
        chk("prio_valid", 32'(instr_valid), 32'd0);
        serve(32'h304, 32'hCAFE_0013, "prio_fetch");

        // Missing response: watchdog when built, indefinite wait otherwise.
        step();
        chk("tmo_addr", imem_addr, 32'h308);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
`ifdef FETCH_CTRL_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tmo_err_early", 32'(fetch_error), 32'd0);
        end
        step();
        chk("tmo_err", 32'(fetch_error), 32'd1);
        chk("tmo_reissue_req", 32'(imem_req), 32'd1);
        chk("tmo_reissue_addr", imem_addr, 32'h308);
        serve(32'h308, 32'h0000_0073, "tmo_refetch");
        chk("tmo_err_sticky", 32'(fetch_error), 32'd1);
`else
        for (int i = 0; i < 6; i++) begin
            step();
            chk("notmo_err", 32'(fetch_error), 32'd0);
            chk("notmo_no_req", 32'(imem_req), 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0073;
        sb_q.push_back({32'h308, 32'h0000_0073});
        step();
        imem_rsp_valid = 1'b0;
        pop_check("notmo_late");
`endif

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
